adder_share_arb: RTL

//  Shares one 16-bit fast_adder_wrapper between two requesters (e.g. ALU

---
 rtl/adder_share_arb.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/adder_share_arb.sv
// adder_share_arb
//   Lets two requesters time-share one external WIDTH-bit adder. A request
//   is granted in IDLE, and its operands are steered to the adder in that
//   same cycle. The adder's sum, overflow and carry are captured at the
//   clock edge and held in HOLD until the owning requester acknowledges.
//   FIXED_PRIO = 0 alternates between requesters that ask at the same time.
//   FIXED_PRIO = 1 makes req0 win every tie.

module adder_share_arb #(
   parameter int WIDTH      = 16,
   parameter bit FIXED_PRIO = 1'b0
) (
   input  logic             clk,
   input  logic             rst,
   // requester 0
   input  logic             req0,
   input  logic [WIDTH-1:0] a0,
   input  logic [WIDTH-1:0] b0,
   input  logic             ci0,
   input  logic             sign0,
   output logic             gnt0,
   output logic             vld0,
   input  logic             ack0,
   // requester 1
   input  logic             req1,
   input  logic [WIDTH-1:0] a1,
   input  logic [WIDTH-1:0] b1,
   input  logic             ci1,
   input  logic             sign1,
   output logic             gnt1,
   output logic             vld1,
   input  logic             ack1,
   // held result, shared by both requesters
   output logic [WIDTH-1:0] res,
   output logic             res_ofl,
   output logic             res_cout,
   output logic             busy,
   // shared adder interface
   output logic [WIDTH-1:0] add_a,
   output logic [WIDTH-1:0] add_b,
   output logic             add_ci,
   output logic             add_sign,
   input  logic [WIDTH-1:0] add_out,
   input  logic             add_ofl,
   input  logic             add_cout
);

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_HOLD = 1'b1
   } state_t;

   state_t           r_state;
   state_t           w_state_nxt;
   logic             r_owner;     // requester that owns the held result
   logic             r_ptr;       // requester preferred on the next tie
   logic [WIDTH-1:0] r_res;
   logic             r_res_ofl;
   logic             r_res_cout;

   logic             w_any_req;
   logic             w_pick1;     // 1 = requester 1 wins this cycle
   logic             w_grant;     // a grant is issued this cycle
   logic             w_owner_ack; // the owner's ack, masked to the owner only

   // Arbitration: pick the winner among the active requests.
   always_comb begin
      w_any_req = req0 | req1;
      if (FIXED_PRIO) begin
         w_pick1 = ~req0;
      end else if (req0 && req1) begin
         w_pick1 = r_ptr;
      end else begin
         w_pick1 = ~req0;
      end
      // Reset has priority, so no grant is visible while rst is high.
      w_grant     = (r_state == ST_IDLE) && w_any_req && !rst;
      w_owner_ack = r_owner ? ack1 : ack0;
   end

   // Next state, grants and adder steering.
   // NOTE: Every output of this block is assigned a default first. That way
   // no path can leave an output unassigned and infer a latch.
   always_comb begin
      w_state_nxt = r_state;
      gnt0        = 1'b0;
      gnt1        = 1'b0;
      add_a       = '0;
      add_b       = '0;
      add_ci      = 1'b0;
      add_sign    = 1'b0;
      unique case (r_state)
         ST_IDLE: begin
            if (w_grant) begin
               w_state_nxt = ST_HOLD;
               gnt0        = ~w_pick1;
               gnt1        = w_pick1;
               add_a       = w_pick1 ? a1    : a0;
               add_b       = w_pick1 ? b1    : b0;
               add_ci      = w_pick1 ? ci1   : ci0;
               add_sign    = w_pick1 ? sign1 : sign0;
            end
         end
         ST_HOLD: begin
            // Only the owner's ack releases the result; the other ack is ignored.
            if (w_owner_ack) begin
               w_state_nxt = ST_IDLE;
            end
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   // State register with synchronous reset.
   // NOTE: Sequential state uses non-blocking assignments. Every register
   // then samples pre-edge values, with no ordering races between blocks.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Owner and round-robin pointer: updated on every grant.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_owner <= 1'b0;
         r_ptr   <= 1'b0;
      end else if (w_grant) begin
         r_owner <= w_pick1;
         r_ptr   <= ~w_pick1;
      end
   end

   // Result capture. The adder output is taken verbatim in the grant cycle
   // and then held unchanged through HOLD.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_res      <= '0;
         r_res_ofl  <= 1'b0;
         r_res_cout <= 1'b0;
      end else if (w_grant) begin
         r_res      <= add_out;
         r_res_ofl  <= add_ofl;
         r_res_cout <= add_cout;
      end
   end

   // Status and result outputs, all driven from registers.
   always_comb begin
      busy     = (r_state == ST_HOLD);
      vld0     = (r_state == ST_HOLD) && !r_owner;
      vld1     = (r_state == ST_HOLD) &&  r_owner;
      res      = r_res;
      res_ofl  = r_res_ofl;
      res_cout = r_res_cout;
   end

endmodule
